// File: rtl/jump_engine.sv
// Jump-physics engine: converts a held jump key into integer-kinematics height/velocity per tick.
// Optional macro JUMP_ENGINE_SHORT_HOP_EN halves upward velocity when the key is released mid-rise.
module jump_engine #(
  parameter int unsigned CLOCK_FREQUENCY = 25000000,
  parameter int unsigned TICKS_PER_SEC   = 4,
  parameter int unsigned H_WIDTH         = 16,
  parameter int unsigned GROUND          = 150,
  parameter int unsigned CEILING         = 0,
  parameter int unsigned JUMP_VEL        = 7,
  parameter int unsigned GRAVITY         = 1,
  parameter int unsigned MAX_JUMPS       = 2
) (
  input  logic                                 Clock,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic                                 freeze,
  input  logic                                 jump_req,
  output logic [H_WIDTH-1:0]                   height,
  output logic [H_WIDTH-1:0]                   velocity,
  output logic                                 airborne,
  output logic [$clog2(MAX_JUMPS+1)-1:0]       jump_count,
  output logic                                 landed,
  output logic                                 tick
);

  localparam int unsigned PERIOD = CLOCK_FREQUENCY / TICKS_PER_SEC;
  localparam int unsigned CW     = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam int unsigned JW     = $clog2(MAX_JUMPS + 1);

  localparam logic signed [H_WIDTH:0]   GROUND_S = (H_WIDTH+1)'(GROUND);
  localparam logic signed [H_WIDTH:0]   CEIL_S   = (H_WIDTH+1)'(CEILING);
  localparam logic [H_WIDTH-1:0]        GROUND_H = H_WIDTH'(GROUND);
  localparam logic [H_WIDTH-1:0]        CEIL_H   = H_WIDTH'(CEILING);
  localparam logic [H_WIDTH-1:0]        JVEL_H   = H_WIDTH'(JUMP_VEL);
  localparam logic signed [H_WIDTH-1:0] GRAV_H   = H_WIDTH'(GRAVITY);
  localparam logic [CW-1:0]             RELOAD   = CW'(PERIOD - 1);
  localparam logic [JW-1:0]             MAXJ     = JW'(MAX_JUMPS);

  typedef enum logic [1:0] {ST_GROUND, ST_RISE, ST_FALL} state_t;

  state_t                     state_q, state_d;
  logic [H_WIDTH-1:0]         height_d, vel_d;
  logic [JW-1:0]              jc_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       jq;
  logic                       landed_d, tick_d;

  logic                       press, air;
  logic signed [H_WIDTH:0]    h_next;
  logic signed [H_WIDTH-1:0]  v_step;
`ifdef JUMP_ENGINE_SHORT_HOP_EN
  logic                       release_ev;
  logic signed [H_WIDTH-1:0]  v_step_half, v_cur_half;
`endif

  // State register; jq samples the key every cycle regardless of enable/freeze
  always_ff @(posedge Clock) begin
    if (!reset) begin
      state_q    <= ST_GROUND;
      height     <= GROUND_H;
      velocity   <= '0;
      jump_count <= '0;
      cnt_q      <= '0;
      airborne   <= 1'b0;
      landed     <= 1'b0;
      tick       <= 1'b0;
      jq         <= 1'b0;
    end else begin
      state_q    <= state_d;
      height     <= height_d;
      velocity   <= vel_d;
      jump_count <= jc_d;
      cnt_q      <= cnt_d;
      airborne   <= (state_d != ST_GROUND);
      landed     <= landed_d;
      tick       <= tick_d;
      jq         <= jump_req;
    end
  end

  // Next-state: press beats a due step; disable forces the ground pose silently
  always_comb begin
    state_d  = state_q;
    height_d = height;
    vel_d    = velocity;
    jc_d     = jump_count;
    cnt_d    = cnt_q;
    landed_d = 1'b0;
    tick_d   = 1'b0;

    press  = jump_req & ~jq;
    air    = (state_q != ST_GROUND);
    h_next = $signed({1'b0, height}) - $signed({velocity[H_WIDTH-1], velocity});
    v_step = $signed(velocity) - GRAV_H;
`ifdef JUMP_ENGINE_SHORT_HOP_EN
    release_ev  = ~jump_req & jq;
    v_step_half = v_step >>> 1;
    v_cur_half  = $signed(velocity) >>> 1;
`endif

    if (!enable) begin
      state_d  = ST_GROUND;
      height_d = GROUND_H;
      vel_d    = '0;
      jc_d     = '0;
      cnt_d    = '0;
    end else if (!freeze) begin
      if (press && (!air || (jump_count < MAXJ))) begin
        vel_d   = JVEL_H;
        jc_d    = jump_count + JW'(1);
        cnt_d   = RELOAD;
        state_d = ST_RISE;
      end else if (air && (cnt_q == '0)) begin
        tick_d = 1'b1;
        cnt_d  = RELOAD;
        if (h_next >= GROUND_S) begin
          height_d = GROUND_H;
          vel_d    = '0;
          jc_d     = '0;
          state_d  = ST_GROUND;
          landed_d = 1'b1;
        end else if (h_next < CEIL_S) begin
          height_d = CEIL_H;
          vel_d    = '0;
          state_d  = ST_FALL;
        end else begin
          height_d = h_next[H_WIDTH-1:0];
          vel_d    = v_step;
          state_d  = (v_step > 0) ? ST_RISE : ST_FALL;
`ifdef JUMP_ENGINE_SHORT_HOP_EN
          if (release_ev && (state_q == ST_RISE)) begin
            vel_d   = v_step_half;
            state_d = (v_step_half > 0) ? ST_RISE : ST_FALL;
          end
`endif
        end
      end else if (air) begin
        cnt_d = cnt_q - CW'(1);
`ifdef JUMP_ENGINE_SHORT_HOP_EN
        if (release_ev && (state_q == ST_RISE)) begin
          vel_d = v_cur_half;
          if (v_cur_half == '0) state_d = ST_FALL;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_jump_engine.sv
// Directed bench for jump_engine at PERIOD=4; a second instance exercises the ceiling clamp.
module tb_jump_engine;

  logic        Clock = 1'b0;
  logic        reset, enable, freeze, jump_req;
  logic [15:0] height, velocity, c_height, c_velocity;
  logic        airborne, landed, tick, c_airborne, c_landed, c_tick;
  logic [1:0]  jump_count, c_jump_count;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 Clock = ~Clock;

  jump_engine #(.CLOCK_FREQUENCY(8), .TICKS_PER_SEC(2)) u_dut (
    .Clock(Clock), .reset(reset), .enable(enable), .freeze(freeze), .jump_req(jump_req),
    .height(height), .velocity(velocity), .airborne(airborne), .jump_count(jump_count),
    .landed(landed), .tick(tick)
  );

  jump_engine #(.CLOCK_FREQUENCY(8), .TICKS_PER_SEC(2), .CEILING(140)) u_ceil (
    .Clock(Clock), .reset(reset), .enable(enable), .freeze(freeze), .jump_req(jump_req),
    .height(c_height), .velocity(c_velocity), .airborne(c_airborne), .jump_count(c_jump_count),
    .landed(c_landed), .tick(c_tick)
  );

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  // Advance until a tick pulse (bounded); returns cycles taken
  task automatic wait_tick(output int cycles);
    cycles = 0;
    do begin
      cyc();
      cycles++;
    end while (!tick && cycles < 40);
    chk("tick_seen", int'(tick), 1);
  endtask

  task automatic wait_ground();
    int k;
    k = 0;
    while ((airborne || c_airborne) && k < 300) begin
      cyc();
      k++;
    end
    chk("ground_reached", int'(airborne), 0);
    cyc();
  endtask

  task automatic press();
    jump_req = 1'b1;
    cyc();
    jump_req = 1'b0;
  endtask

  initial begin
    int exp_h[15];
    exp_h = '{143, 137, 132, 128, 125, 123, 122, 122, 123, 125, 128, 132, 137, 143, 150};

    reset = 1'b0; enable = 1'b0; freeze = 1'b0; jump_req = 1'b0;
    cyc(); cyc();
    chk("rst_height", int'(height), 150);
    chk("rst_vel", int'(velocity), 0);
    chk("rst_air", int'(airborne), 0);
    chk("rst_jc", int'(jump_count), 0);
    chk("rst_landed", int'(landed), 0);
    chk("rst_tick", int'(tick), 0);
    reset = 1'b1; enable = 1'b1;
    cyc(); cyc();

    // Single jump with full trajectory
    press();
    chk("sj_air", int'(airborne), 1);
    chk("sj_vel", int'($signed(velocity)), 7);
    chk("sj_jc", int'(jump_count), 1);
    for (int i = 0; i < 15; i++) begin
      wait_tick(n);
      if (i == 0) begin
        chk("sj_first_latency", n, 4);
        chk("ceil_t1", int'(c_height), 143);
      end
      if (i == 1) begin
        chk("ceil_t2_h", int'(c_height), 140);
        chk("ceil_t2_v", int'(c_velocity), 0);
      end
      if (i == 6) chk("sj_apex_v", int'($signed(velocity)), 0);
      chk($sformatf("sj_h%0d", i + 1), int'(height), exp_h[i]);
      chk($sformatf("sj_landed%0d", i + 1), int'(landed), (i == 14) ? 1 : 0);
    end
    chk("sj_jc_end", int'(jump_count), 0);
    chk("sj_air_end", int'(airborne), 0);
    wait_ground();

    // Double jump, third press ignored
    press();
    for (int i = 0; i < 3; i++) wait_tick(n);
    chk("dj_h3", int'(height), 132);
    press();
    chk("dj_vel", int'($signed(velocity)), 7);
    chk("dj_jc", int'(jump_count), 2);
    wait_tick(n);
    chk("dj_h4", int'(height), 125);
    press();
    chk("dj_third_jc", int'(jump_count), 2);
    chk("dj_third_vel", int'($signed(velocity)), 6);
    wait_ground();

    // Freeze at h=137 with a discarded press
    press();
    wait_tick(n); wait_tick(n);
    chk("fz_h", int'(height), 137);
    cyc();
    freeze = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) jump_req = 1'b1;
      if (i == 7) jump_req = 1'b0;
      cyc();
      if (tick) n++;
    end
    chk("fz_ticks", n, 0);
    chk("fz_hold_h", int'(height), 137);
    chk("fz_hold_v", int'($signed(velocity)), 5);
    chk("fz_jc", int'(jump_count), 1);
    freeze = 1'b0;
    wait_tick(n);
    chk("fz_resume_cycles", n, 3);
    chk("fz_resume_h", int'(height), 132);
    wait_ground();

    // Disable mid-jump at h=128
    press();
    for (int i = 0; i < 4; i++) wait_tick(n);
    chk("dis_pre_h", int'(height), 128);
    enable = 1'b0;
    cyc();
    chk("dis_h", int'(height), 150);
    chk("dis_air", int'(airborne), 0);
    chk("dis_landed", int'(landed), 0);
    chk("dis_jc", int'(jump_count), 0);
    enable = 1'b1;
    cyc();

    // Reset mid-jump at h=128
    press();
    for (int i = 0; i < 4; i++) wait_tick(n);
    chk("rmj_pre_h", int'(height), 128);
    reset = 1'b0;
    cyc();
    chk("rmj_h", int'(height), 150);
    chk("rmj_vel", int'(velocity), 0);
    chk("rmj_air", int'(airborne), 0);
    chk("rmj_jc", int'(jump_count), 0);
    chk("rmj_tick", int'(tick), 0);
    reset = 1'b1;
    cyc(); cyc();

    // Release after tick 1 (short hop only when the macro is defined)
    jump_req = 1'b1;
    cyc();
    wait_tick(n);
    chk("sh_v1", int'($signed(velocity)), 6);
    jump_req = 1'b0;
    cyc();
`ifdef JUMP_ENGINE_SHORT_HOP_EN
    chk("sh_vel", int'($signed(velocity)), 3);
    wait_tick(n);
    chk("sh_h2", int'(height), 140);
`else
    chk("sh_vel", int'($signed(velocity)), 6);
    wait_tick(n);
    chk("sh_h2", int'(height), 137);
`endif
    wait_ground();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
